// File: rtl/exe_stage_mc.sv
`default_nettype none
// ==== exe_stage_mc : registered execute stage (Val2, ALU, flags, branch adder, iterative MUL) -- rev 1.0 ====
module exe_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [3:0]       EXE_CMD,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic             S,
  input  logic             imm,
  input  logic             WB_EN,
  input  logic             B,
  input  logic [3:0]       Dest,
  input  logic [WIDTH-1:0] Val_Rn,
  input  logic [WIDTH-1:0] Val_Rm,
  input  logic [11:0]      Shift_operand,
  input  logic [23:0]      Signed_imm_24,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_res,
  output logic [WIDTH-1:0] out_store_data,
  output logic             out_mem_r,
  output logic             out_mem_w,
  output logic             out_wb_en,
  output logic [3:0]       out_dest,
  output logic [3:0]       statusRegs,
  output logic             branch_taken,
  output logic [WIDTH-1:0] new_branch_addr
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_MVN = 4'b1001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_SBC = 4'b0101;
  localparam logic [3:0] C_AND = 4'b0110;
  localparam logic [3:0] C_ORR = 4'b0111;
  localparam logic [3:0] C_EOR = 4'b1000;
  localparam logic [3:0] C_MUL = 4'b1010;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
  state_t r_state;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int unsigned amt);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> (amt % 32'(WIDTH));
    return d[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] w_val2, w_rm_sh, w_imm8;
  logic [4:0]       w_sh_amt;

  always_comb begin
    w_imm8   = {{(WIDTH-8){1'b0}}, Shift_operand[7:0]};
    w_sh_amt = Shift_operand[11:7];
    case (Shift_operand[6:5])
      2'b00:   w_rm_sh = Val_Rm << w_sh_amt;
      2'b01:   w_rm_sh = Val_Rm >> w_sh_amt;
      2'b10:   w_rm_sh = $unsigned($signed(Val_Rm) >>> w_sh_amt);
      default: w_rm_sh = ror(Val_Rm, 32'(w_sh_amt));
    endcase
    if (MEM_R_EN | MEM_W_EN)
      w_val2 = {{(WIDTH-12){1'b0}}, Shift_operand};
    else if (imm)
      w_val2 = ror(w_imm8, 32'({Shift_operand[11:8], 1'b0}));
    else
      w_val2 = w_rm_sh;
  end

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = statusRegs[1];
    w_v   = statusRegs[0];
    case (EXE_CMD)
      C_MOV: w_res = w_val2;
      C_MVN: w_res = ~w_val2;
      C_ADD, C_ADC: begin
        w_sum = {1'b0, Val_Rn} + {1'b0, w_val2}
              + {{WIDTH{1'b0}}, (EXE_CMD == C_ADC) & statusRegs[1]};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (Val_Rn[WIDTH-1] == w_val2[WIDTH-1]) && (w_res[WIDTH-1] != Val_Rn[WIDTH-1]);
      end
      C_SUB, C_SBC: begin
        // C is the inverted borrow out of the (WIDTH+1)-bit difference
        w_sum = {1'b0, Val_Rn} - {1'b0, w_val2}
              - {{WIDTH{1'b0}}, (EXE_CMD == C_SBC) & ~statusRegs[1]};
        w_res = w_sum[WIDTH-1:0];
        w_c   = ~w_sum[WIDTH];
        w_v   = (Val_Rn[WIDTH-1] != w_val2[WIDTH-1]) && (w_res[WIDTH-1] != Val_Rn[WIDTH-1]);
      end
      C_AND: w_res = Val_Rn & w_val2;
      C_ORR: w_res = Val_Rn | w_val2;
      C_EOR: w_res = Val_Rn ^ w_val2;
      default: w_res = '0;
    endcase
  end

  logic [WIDTH-1:0] w_off, w_br_addr;

  generate
    if (WIDTH >= 24) begin : g_off_wide
      assign w_off = {{(WIDTH-24){Signed_imm_24[23]}}, Signed_imm_24};
    end else begin : g_off_narrow
      assign w_off = Signed_imm_24[WIDTH-1:0];
    end
  endgenerate

  assign w_br_addr = pc_in + (w_off << BR_SHIFT);

  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_pp, w_acc_next;
  logic [CNT_W-1:0] r_cnt;

  // Shift-add over MUL_STEP multiplier bits per cycle; only the low WIDTH product bits are kept
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_STEP; j++)
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    w_acc_next = r_acc + w_pp;
  end

  logic [WIDTH-1:0] r_p_store, r_p_br;
  logic [3:0]       r_p_dest;
  logic             r_p_wb, r_p_mr, r_p_mw, r_p_b, r_p_s;
  logic             w_accept;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      out_valid       <= 1'b0;
      out_res         <= '0;
      out_store_data  <= '0;
      out_mem_r       <= 1'b0;
      out_mem_w       <= 1'b0;
      out_wb_en       <= 1'b0;
      out_dest        <= '0;
      statusRegs      <= '0;
      branch_taken    <= 1'b0;
      new_branch_addr <= '0;
      r_mcand         <= '0;
      r_mplier        <= '0;
      r_acc           <= '0;
      r_cnt           <= '0;
      r_p_store       <= '0;
      r_p_br          <= '0;
      r_p_dest        <= '0;
      r_p_wb          <= 1'b0;
      r_p_mr          <= 1'b0;
      r_p_mw          <= 1'b0;
      r_p_b           <= 1'b0;
      r_p_s           <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && EXE_CMD == C_MUL) begin
            r_state   <= MUL_BUSY;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= Val_Rn;
            r_mplier  <= w_val2;
            r_p_store <= Val_Rm;
            r_p_br    <= w_br_addr;
            r_p_dest  <= Dest;
            r_p_wb    <= WB_EN;
            r_p_mr    <= MEM_R_EN;
            r_p_mw    <= MEM_W_EN;
            r_p_b     <= B;
            r_p_s     <= S;
          end else if (w_accept) begin
            out_valid       <= 1'b1;
            out_res         <= w_res;
            out_store_data  <= Val_Rm;
            out_mem_r       <= MEM_R_EN;
            out_mem_w       <= MEM_W_EN;
            out_wb_en       <= WB_EN;
            out_dest        <= Dest;
            branch_taken    <= B;
            new_branch_addr <= w_br_addr;
            if (S) statusRegs <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
          end
        end
        MUL_BUSY: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) begin
              r_state         <= IDLE;
              out_valid       <= 1'b1;
              out_res         <= w_acc_next;
              out_store_data  <= r_p_store;
              out_mem_r       <= r_p_mr;
              out_mem_w       <= r_p_mw;
              out_wb_en       <= r_p_wb;
              out_dest        <= r_p_dest;
              branch_taken    <= r_p_b;
              new_branch_addr <= r_p_br;
              if (r_p_s) statusRegs[3:2] <= {w_acc_next[WIDTH-1], (w_acc_next == '0)};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
